smart_intersection_controller: RTL and testbench
================================================

SMART_INTERSECTION_CONTROLLER -- requirements
Module: smart_intersection_controller

Interface
REQ-001 SHALL accept parameter N_DIR, 4, number of approaches (2..8).
REQ-002 SHALL accept parameter GREEN_T, 8, green phase length in cycles (>=1).
REQ-003 SHALL accept parameter YELLOW_T, 3, yellow phase length in cycles (>=1).
REQ-004 SHALL accept parameter ALLRED_T, 2, all-red clearance length in cycles (>=1).
REQ-005 SHALL accept parameter WALK_T, 6, pedestrian walk length in cycles (>=1).
REQ-006 SHALL accept parameter PARK_CAP, 10, parking capacity (1..2^PARK_W-1).
REQ-007 SHALL accept parameter PARK_W, 4, width of parking_slots.
REQ-008 SHALL have ports, one per line:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- car_sensor  input  N_DIR  per-approach car-waiting pulse or level.
- pedestrian_req  input  1  pedestrian crossing request.
- emergency  input  1  emergency-vehicle override, level.
- emergency_dir  input  clog2(N_DIR)  approach to give green during override.
- car_enter  input  1  one car entered parking this cycle.
- car_exit  input  1  one car left parking this cycle.
- traffic_light  output  2*N_DIR  2 bits per approach i at [2i+1:2i]: 00 red, 01 yellow, 10 green; 11 never driven.
- active_dir  output  clog2(N_DIR)  approach currently or most recently served.
- pedestrian_green  output  1  walk signal.
- emergency_active  output  1  override in force.
- parking_slots  output  PARK_W  free parking slots.
- parking_full  output  1  parking_slots == 0.

Function
REQ-009 SHALL implement states ALL_RED, GREEN, YELLOW, PED_WALK, EMERG; all outputs registered, functions of state only.
REQ-010 SHALL hold each timed state exactly its parameter length in cycles (ALL_RED ALLRED_T, GREEN GREEN_T, YELLOW YELLOW_T, PED_WALK WALK_T), counting from the entry edge.
REQ-011 SHALL latch any car_sensor[i]=1 into sticky car_pend[i], cleared on the edge that enters GREEN for approach i (a new request on that same edge is lost).
REQ-012 SHALL latch pedestrian_req=1 into sticky ped_pend, cleared on the edge that enters PED_WALK.
REQ-013 SHALL, at ALL_RED expiry: go PED_WALK if ped_pend; else GREEN on first pending approach searching active_dir+1, +2, ... wrapping modulo N_DIR (active_dir itself last); else remain ALL_RED, re-evaluating every cycle.
REQ-014 SHALL, in GREEN, drive only active_dir green; at expiry go YELLOW (same approach yellow), at YELLOW expiry go ALL_RED.
REQ-015 SHALL, in PED_WALK, drive all approaches red and pedestrian_green=1; at expiry go ALL_RED; active_dir unchanged.
REQ-016 SHALL, when emergency=1 in any state, enter EMERG on next edge, overriding all other transitions; emergency has priority over timers and requests.
REQ-017 SHALL, in EMERG, drive approach emergency_dir (sampled every cycle) green, all others red, pedestrian_green=0, emergency_active=1, active_dir=emergency_dir.
REQ-018 SHALL, on first edge with emergency=0 in EMERG, go ALL_RED with full ALLRED_T; pending requests retained throughout.
REQ-019 SHALL decrement parking_slots on car_enter when >0, increment on car_exit when <PARK_CAP, no change when both asserted, and saturate silently at 0 and PARK_CAP.
REQ-020 SHALL run parking logic independently of intersection state, including during EMERG.

Reset
REQ-021 SHALL, on reset=1 at an edge: state ALL_RED with timer restarted, all lights 00, active_dir=N_DIR-1 (so first search starts at 0), pedestrian_green=0, emergency_active=0, car_pend=0, ped_pend=0, parking_slots=PARK_CAP, parking_full=0.
REQ-022 SHALL give reset priority over emergency and all inputs, including mid-phase.

Verification (defaults)
REQ-023 Reset, car_sensor=4'b0100 one cycle -> after 2 ALL_RED cycles approach 2 green 8 cycles, yellow 3, red; active_dir=2.
REQ-024 car_sensor=4'b1001 held while approach 2 served -> next greens approach 3 then 0 (round-robin wrap).
REQ-025 pedestrian_req pulse during GREEN -> GREEN/YELLOW complete, 2 ALL_RED, pedestrian_green=1 for 6 cycles, all lights red.
REQ-026 emergency=1, emergency_dir=1 mid-GREEN on approach 3 -> next cycle traffic_light=8'b00_00_10_00, emergency_active=1; release -> 2 ALL_RED cycles then pending service resumes.
REQ-027 11 car_enter pulses -> parking_slots 10..0, parking_full=1, stays 0; car_enter+car_exit same cycle -> no change; car_exit at 10 -> stays 10.
REQ-028 reset asserted during PED_WALK -> next cycle pedestrian_green=0, all red, pending cleared.

Source files
------------

// File: rtl/smart_intersection_controller.sv
// smart_intersection_controller: round-robin traffic light FSM with pedestrian phase, emergency override and parking counter
module smart_intersection_controller #(
  parameter int N_DIR    = 4,
  parameter int GREEN_T  = 8,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 2,
  parameter int WALK_T   = 6,
  parameter int PARK_CAP = 10,
  parameter int PARK_W   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_DIR-1:0]           car_sensor,
  input  logic                       pedestrian_req,
  input  logic                       emergency,
  input  logic [$clog2(N_DIR)-1:0]   emergency_dir,
  input  logic                       car_enter,
  input  logic                       car_exit,
  output logic [2*N_DIR-1:0]         traffic_light,
  output logic [$clog2(N_DIR)-1:0]   active_dir,
  output logic                       pedestrian_green,
  output logic                       emergency_active,
  output logic [PARK_W-1:0]          parking_slots,
  output logic                       parking_full
);
  localparam int DW = $clog2(N_DIR);
  typedef enum logic [2:0] {ALL_RED, GREEN, YELLOW, PED_WALK, EMERG} state_t;
  state_t state, state_n;
  logic [15:0] timer, dur_m1;
  logic [N_DIR-1:0] car_pend, grant;
  logic ped_pend, expired, found;
  logic [DW-1:0] active_dir_n, next_dir, idx;
  logic [1:0] lamp;
  always_comb begin
    dur_m1 = state == GREEN ? 16'(GREEN_T - 1) : state == YELLOW ? 16'(YELLOW_T - 1) :
             state == PED_WALK ? 16'(WALK_T - 1) : state == ALL_RED ? 16'(ALLRED_T - 1) : 16'd0;
    expired = timer == dur_m1;
    found = 1'b0;
    next_dir = active_dir;
    idx = '0;
    // walk downwards so the nearest approach after active_dir wins
    for (int k = N_DIR; k >= 1; k--) begin
      idx = DW'((int'(active_dir) + k) % N_DIR);
      if (car_pend[idx]) begin
        found = 1'b1;
        next_dir = idx;
      end
    end
    state_n = state;
    active_dir_n = active_dir;
    grant = '0;
    if (emergency) begin
      state_n = EMERG;
      active_dir_n = emergency_dir;
    end else if (state == EMERG) state_n = ALL_RED;
    else if (expired)
      unique case (state)
        ALL_RED:
          if (ped_pend) state_n = PED_WALK;
          else if (found) begin
            state_n = GREEN;
            active_dir_n = next_dir;
            grant[next_dir] = 1'b1;
          end
        GREEN: state_n = YELLOW;
        default: state_n = ALL_RED;
      endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= ALL_RED;
      timer <= '0;
      active_dir <= DW'(N_DIR - 1);
      car_pend <= '0;
      ped_pend <= 1'b0;
      parking_slots <= PARK_W'(PARK_CAP);
    end else begin
      state <= state_n;
      timer <= state_n != state ? 16'd0 : expired ? timer : timer + 16'd1;
      active_dir <= active_dir_n;
      car_pend <= (car_pend | car_sensor) & ~grant;
      ped_pend <= (ped_pend | pedestrian_req) & ~(state == ALL_RED && state_n == PED_WALK);
      if (car_enter && !car_exit && parking_slots != '0)
        parking_slots <= parking_slots - PARK_W'(1);
      else if (car_exit && !car_enter && parking_slots != PARK_W'(PARK_CAP))
        parking_slots <= parking_slots + PARK_W'(1);
    end
  always_comb begin
    lamp = (state == GREEN || state == EMERG) ? 2'b10 : state == YELLOW ? 2'b01 : 2'b00;
    traffic_light = '0;
    for (int i = 0; i < N_DIR; i++)
      traffic_light[2*i +: 2] = active_dir == DW'(i) ? lamp : 2'b00;
  end
  assign pedestrian_green = state == PED_WALK;
  assign emergency_active = state == EMERG;
  assign parking_full = parking_slots == '0;
endmodule

// File: tb/tb_smart_intersection_controller.sv
// tb_smart_intersection_controller: directed scenarios then random traffic, checked each cycle against a countdown reference model
module tb_smart_intersection_controller;
  localparam int N = 4, GT = 8, YT = 3, AT = 2, WT = 6, CAP = 10;
  localparam int AR = 0, G = 1, Y = 2, WK = 3, EM = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] car_sensor = '0;
  logic pedestrian_req = 1'b0, emergency = 1'b0, car_enter = 1'b0, car_exit = 1'b0;
  logic [1:0] emergency_dir = '0;
  logic [7:0] traffic_light;
  logic [1:0] active_dir;
  logic pedestrian_green, emergency_active, parking_full;
  logic [3:0] parking_slots;
  int total = 0, bad = 0;
  int m_phase, m_left, m_dir, m_slots;
  bit [3:0] m_cpend;
  bit m_ppend;

  smart_intersection_controller #(.N_DIR(N), .GREEN_T(GT), .YELLOW_T(YT), .ALLRED_T(AT),
    .WALK_T(WT), .PARK_CAP(CAP), .PARK_W(4)) dut (
    .clk(clk), .reset(reset), .car_sensor(car_sensor), .pedestrian_req(pedestrian_req),
    .emergency(emergency), .emergency_dir(emergency_dir), .car_enter(car_enter),
    .car_exit(car_exit), .traffic_light(traffic_light), .active_dir(active_dir),
    .pedestrian_green(pedestrian_green), .emergency_active(emergency_active),
    .parking_slots(parking_slots), .parking_full(parking_full));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // each phase keeps a count of cycles left; decisions use the requests seen before this edge
  task automatic model_step();
    bit [3:0] oc;
    bit op;
    int d;
    if (reset) begin
      m_phase = AR; m_left = AT; m_dir = N - 1; m_cpend = '0; m_ppend = 0; m_slots = CAP;
      return;
    end
    if (car_enter && !car_exit && m_slots > 0) m_slots--;
    else if (car_exit && !car_enter && m_slots < CAP) m_slots++;
    oc = m_cpend; op = m_ppend;
    m_cpend |= car_sensor;
    m_ppend |= pedestrian_req;
    if (emergency) begin m_phase = EM; m_dir = int'(emergency_dir); return; end
    if (m_phase == EM) begin m_phase = AR; m_left = AT; return; end
    if (m_left > 1) begin m_left--; return; end
    case (m_phase)
      AR:
        if (op) begin m_phase = WK; m_left = WT; m_ppend = 0; end
        else
          for (int k = 1; k <= N; k++) begin
            d = (m_dir + k) % N;
            if (oc[d]) begin m_phase = G; m_dir = d; m_left = GT; m_cpend[d] = 0; break; end
          end
      G: begin m_phase = Y; m_left = YT; end
      default: begin m_phase = AR; m_left = AT; end
    endcase
  endtask

  function automatic logic [7:0] m_lights();
    logic [7:0] l;
    l = '0;
    if (m_phase == G || m_phase == EM) l[2*m_dir +: 2] = 2'b10;
    else if (m_phase == Y) l[2*m_dir +: 2] = 2'b01;
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("lights", traffic_light, m_lights());
    chk("active_dir", active_dir, m_dir);
    chk("ped_green", pedestrian_green, m_phase == WK);
    chk("emerg_active", emergency_active, m_phase == EM);
    chk("slots", parking_slots, m_slots);
    chk("full", parking_full, m_slots == 0);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    tick();
    reset = 0;
    chk("rst_lights", traffic_light, 8'h00);
    chk("rst_dir", active_dir, 2'd3);
    chk("rst_slots", parking_slots, 4'd10);
    chk("rst_full", parking_full, 1'b0);
    chk("rst_ped", pedestrian_green, 1'b0);
    chk("rst_em", emergency_active, 1'b0);
    car_sensor = 4'b0100; tick();
    car_sensor = 4'b1001; tick();
    chk("green2", traffic_light, 8'h20);
    chk("dir2", active_dir, 2'd2);
    run(7);
    car_sensor = 4'b0000; tick();
    chk("yellow2", traffic_light, 8'h10);
    run(3);
    chk("red_after2", traffic_light, 8'h00);
    run(2);
    chk("green3", traffic_light, 8'h80);
    run(7); tick();
    chk("yellow3", traffic_light, 8'h40);
    run(3); run(2);
    chk("green0_wrap", traffic_light, 8'h02);
    pedestrian_req = 1; tick();
    pedestrian_req = 0; run(6);
    tick();
    chk("yellow0", traffic_light, 8'h01);
    run(3); run(2);
    chk("walk_on", pedestrian_green, 1'b1);
    chk("walk_red", traffic_light, 8'h00);
    run(5);
    chk("walk_last", pedestrian_green, 1'b1);
    tick();
    chk("walk_off", pedestrian_green, 1'b0);
    car_sensor = 4'b1000; tick();
    car_sensor = 4'b0000; tick();
    chk("green3_b", traffic_light, 8'h80);
    run(2);
    emergency = 1; emergency_dir = 2'd1; tick();
    chk("em_lights", traffic_light, 8'h08);
    chk("em_active", emergency_active, 1'b1);
    chk("em_dir", active_dir, 2'd1);
    pedestrian_req = 1; car_sensor = 4'b0001; tick();
    pedestrian_req = 0; car_sensor = 4'b0000; tick();
    emergency = 0; tick();
    chk("em_release_red", traffic_light, 8'h00);
    chk("em_release_flag", emergency_active, 1'b0);
    run(2);
    chk("resume_walk", pedestrian_green, 1'b1);
    tick();
    reset = 1; tick();
    reset = 0;
    chk("rst_walk_ped", pedestrian_green, 1'b0);
    chk("rst_walk_red", traffic_light, 8'h00);
    run(4);
    chk("rst_pend_cleared", traffic_light, 8'h00);
    car_enter = 1; run(11);
    chk("park_empty", parking_slots, 4'd0);
    chk("park_full", parking_full, 1'b1);
    car_exit = 1; tick();
    chk("park_both_at0", parking_slots, 4'd0);
    car_enter = 0; run(3);
    car_enter = 1; tick();
    chk("park_both_mid", parking_slots, 4'd3);
    car_enter = 0; run(7); tick();
    chk("park_cap", parking_slots, 4'd10);
    car_exit = 0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom % 400) == 0;
      car_sensor = ($urandom % 4 == 0) ? 4'($urandom) : 4'd0;
      pedestrian_req = ($urandom % 20) == 0;
      emergency = emergency ? ($urandom % 8 != 0) : ($urandom % 150 == 0);
      emergency_dir = 2'($urandom);
      car_enter = ($urandom % 3) == 0;
      car_exit = ($urandom % 3) == 0;
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
